// File: rtl/capsense_csd_scan_sequencer.sv
// Scan sequencer for a CSD capacitive-sense measure channel: walks the enabled sensors,
// settles the analog mux, runs one measurement per sensor and streams the raw counts out.
module capsense_csd_scan_sequencer #(
    parameter int NumSensors    = 16,
    parameter int SelWidth      = 4,
    parameter int CountWidth    = 16,
    parameter int SettleCycles  = 8,
    parameter int TimeoutCycles = 4096
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_enable,
    input  logic                  i_scan_req,
    input  logic [NumSensors-1:0] i_scan_mask,
    output logic                  o_meas_start,
    input  logic                  i_meas_done,
    input  logic [CountWidth-1:0] i_meas_count,
    output logic [SelWidth-1:0]   o_sensor_sel,
    output logic                  o_sensor_en,
    output logic                  o_raw_valid,
    input  logic                  i_raw_ready,
    output logic [CountWidth-1:0] o_raw_data,
    output logic [SelWidth-1:0]   o_raw_sensor,
    output logic                  o_raw_timeout,
    output logic                  o_busy,
    output logic                  o_scan_done
);
    typedef enum logic [2:0] {
        S_IDLE, S_FIND, S_SETTLE, S_WAIT, S_OUT, S_RELEASE, S_DONE
    } state_t;

    localparam logic [7:0]          SettleLoad  = 8'(SettleCycles - 1);
    localparam logic [15:0]         TimeoutLast = 16'(TimeoutCycles - 1);
    localparam logic [SelWidth-1:0] LastIndex   = SelWidth'(NumSensors - 1);

    logic [1:0]            r_rst_sync;
    logic                  w_rst_n;
    state_t                r_state;
    state_t                w_state_next;
    logic [NumSensors-1:0] r_mask;
    logic [SelWidth-1:0]   r_index;
    logic [SelWidth-1:0]   r_sensor_sel;
    logic [SelWidth-1:0]   r_raw_sensor;
    logic [7:0]            r_settle_cnt;
    logic [15:0]           r_tmo_cnt;
    logic [CountWidth-1:0] r_raw_data;
    logic                  r_sensor_en;
    logic                  r_raw_timeout;
    logic [NumSensors-1:0] w_cand;
    logic [SelWidth-1:0]   w_found_idx;
    logic                  w_found;

    // Reset bridge: assertion reaches the core at once, release only after two clock edges.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    genvar gi;
    generate
        for (gi = 0; gi < NumSensors; gi++) begin : g_cand
            assign w_cand[gi] = r_mask[gi] && (32'(gi) >= 32'(r_index));
        end
    endgenerate

    always_comb begin
        w_found     = 1'b0;
        w_found_idx = '0;
        for (int i = NumSensors - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_found     = 1'b1;
                w_found_idx = SelWidth'(i);
            end
        end
    end

    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n)      r_state <= S_IDLE;
        else if (i_enable) r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (i_scan_req) w_state_next = S_FIND;
            S_FIND:    w_state_next = w_found ? S_SETTLE : S_DONE;
            S_SETTLE:  if (r_settle_cnt == 8'd0) w_state_next = S_WAIT;
            S_WAIT:    if (i_meas_done || r_tmo_cnt == TimeoutLast) w_state_next = S_OUT;
            S_OUT:     if (i_raw_ready) w_state_next = S_RELEASE;
            S_RELEASE: if (!i_meas_done) w_state_next = (r_index == LastIndex) ? S_DONE : S_FIND;
            S_DONE:    w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_mask        <= '0;
            r_index       <= '0;
            r_sensor_sel  <= '0;
            r_sensor_en   <= 1'b0;
            r_settle_cnt  <= '0;
            r_tmo_cnt     <= '0;
            r_raw_data    <= '0;
            r_raw_sensor  <= '0;
            r_raw_timeout <= 1'b0;
        end else if (i_enable) begin
            case (r_state)
                S_IDLE: begin
                    if (i_scan_req) begin
                        r_mask  <= i_scan_mask;
                        r_index <= '0;
                    end
                end
                S_FIND: begin
                    if (w_found) begin
                        r_index      <= w_found_idx;
                        r_sensor_sel <= w_found_idx;
                        r_sensor_en  <= 1'b1;
                        r_settle_cnt <= SettleLoad;
                    end
                end
                S_SETTLE: begin
                    if (r_settle_cnt == 8'd0) r_tmo_cnt    <= '0;
                    else                      r_settle_cnt <= r_settle_cnt - 8'd1;
                end
                S_WAIT: begin
                    // A real result wins over a timeout that expires in the same cycle.
                    if (i_meas_done) begin
                        r_raw_data    <= i_meas_count;
                        r_raw_sensor  <= r_index;
                        r_raw_timeout <= 1'b0;
                    end else if (r_tmo_cnt == TimeoutLast) begin
                        r_raw_data    <= '0;
                        r_raw_sensor  <= r_index;
                        r_raw_timeout <= 1'b1;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 16'd1;
                    end
                end
                S_RELEASE: begin
                    if (!i_meas_done) begin
                        r_sensor_en     <= 1'b0;
                        r_mask[r_index] <= 1'b0;
                        if (r_index != LastIndex) r_index <= r_index + SelWidth'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_meas_start  = (r_state == S_WAIT);
    assign o_raw_valid   = (r_state == S_OUT);
    assign o_busy        = (r_state != S_IDLE);
    assign o_scan_done   = (r_state == S_DONE);
    assign o_sensor_sel  = r_sensor_sel;
    assign o_sensor_en   = r_sensor_en;
    assign o_raw_data    = r_raw_data;
    assign o_raw_sensor  = r_raw_sensor;
    assign o_raw_timeout = r_raw_timeout;
endmodule

// File: tb/tb_capsense_csd_scan_sequencer.sv
// Directed bench for the CSD scan sequencer with a small measure-channel model
// that answers meas_start with a configurable delay and count.
module tb_capsense_csd_scan_sequencer;
    localparam int N  = 16;
    localparam int SW = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          enable = 1'b1;
    logic          scan_req = 1'b0;
    logic [N-1:0]  scan_mask = '0;
    logic          meas_start;
    logic          meas_done = 1'b0;
    logic [CW-1:0] meas_count = 16'hBEEF;
    logic [SW-1:0] sensor_sel;
    logic          sensor_en;
    logic          raw_valid;
    logic          raw_ready = 1'b1;
    logic [CW-1:0] raw_data;
    logic [SW-1:0] raw_sensor;
    logic          raw_timeout;
    logic          busy;
    logic          scan_done;

    capsense_csd_scan_sequencer #(
        .NumSensors(N), .SelWidth(SW), .CountWidth(CW), .SettleCycles(8), .TimeoutCycles(4096)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_scan_req(scan_req),
        .i_scan_mask(scan_mask), .o_meas_start(meas_start), .i_meas_done(meas_done),
        .i_meas_count(meas_count), .o_sensor_sel(sensor_sel), .o_sensor_en(sensor_en),
        .o_raw_valid(raw_valid), .i_raw_ready(raw_ready), .o_raw_data(raw_data),
        .o_raw_sensor(raw_sensor), .o_raw_timeout(raw_timeout), .o_busy(busy),
        .o_scan_done(scan_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    // Channel model: done rises ch_delay cycles after meas_start, falls once meas_start drops.
    int            ch_delay   = 50;
    logic [CW-1:0] ch_base    = 16'h1234;
    bit            ch_add_idx = 1'b0;
    bit            ch_hang    = 1'b0;
    logic [SW-1:0] ch_hang_sel = '0;
    int            ch_cnt = 0;
    always @(negedge clk) begin
        if (!meas_start) begin
            ch_cnt     <= 0;
            meas_done  <= 1'b0;
            meas_count <= 16'hBEEF;
        end else if (!meas_done && !(ch_hang && sensor_sel == ch_hang_sel)) begin
            ch_cnt <= ch_cnt + 1;
            if (ch_cnt + 1 == ch_delay) begin
                meas_done  <= 1'b1;
                meas_count <= ch_base + (ch_add_idx ? 16'(sensor_sel) : 16'h0000);
            end
        end
    end

    // Monitor: logs each result, measurement start and scan_done pulse.
    int            n_start = 0, n_done_p = 0, n_res = 0, sel_bad = 0;
    int            start_cyc = 0, en_cyc = 0, done_cyc = 0;
    logic [SW-1:0] start_sel = '0;
    logic          prev_start = 1'b0, prev_en = 1'b0, prev_valid = 1'b0;
    logic [SW-1:0] res_sensor [0:63];
    logic [CW-1:0] res_data   [0:63];
    logic          res_to     [0:63];
    int            res_lat    [0:63];
    always @(negedge clk) begin
        if (meas_start && !prev_start) begin
            n_start   <= n_start + 1;
            start_cyc <= cyc;
            start_sel <= sensor_sel;
        end
        if (meas_start && prev_start && sensor_sel != start_sel) sel_bad <= sel_bad + 1;
        if (sensor_en && !prev_en) en_cyc <= cyc;
        if (raw_valid && !prev_valid && n_res < 64) begin
            res_sensor[n_res] <= raw_sensor;
            res_data[n_res]   <= raw_data;
            res_to[n_res]     <= raw_timeout;
            res_lat[n_res]    <= cyc - start_cyc;
            n_res             <= n_res + 1;
            $display("[%0d] result sensor=%0d data=%h timeout=%0b", cyc, raw_sensor, raw_data, raw_timeout);
        end
        if (scan_done) begin
            n_done_p <= n_done_p + 1;
            done_cyc <= cyc;
        end
        prev_start <= meas_start;
        prev_en    <= sensor_en;
        prev_valid <= raw_valid;
    end

    int req_cyc = 0;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic run_scan(input logic [N-1:0] mask);
        tick();
        scan_mask = mask;
        scan_req  = 1'b1;
        req_cyc   = cyc;
        tick();
        scan_req  = 1'b0;
    endtask

    task automatic wait_scan_done(input int limit, input string name);
        int base = n_done_p;
        int k = 0;
        while (n_done_p == base && k < limit) begin
            tick();
            k++;
        end
        n_checks++;
        if (n_done_p == base) $display("FAIL %s: scan_done not seen within %0d cycles, required a pulse", name, limit);
        else n_pass++;
    endtask

    task automatic wait_sig(input int which, input int limit, input string name);
        int k = 0;
        logic s;
        s = (which == 0) ? raw_valid : (which == 1) ? sensor_en : meas_start;
        while (!s && k < limit) begin
            tick();
            k++;
            s = (which == 0) ? raw_valid : (which == 1) ? sensor_en : meas_start;
        end
        n_checks++;
        if (!s) $display("FAIL %s: signal %0d still low after %0d cycles, required high", name, which, limit);
        else n_pass++;
    endtask

    task automatic set_channel(input int dly, input logic [CW-1:0] base, input bit add_idx);
        ch_delay   = dly;
        ch_base    = base;
        ch_add_idx = add_idx;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (3) tick();
        n_checks += 9;
        if (meas_start !== 1'b0)  $display("FAIL reset_meas_start: got %b expected 0", meas_start);  else n_pass++;
        if (sensor_sel !== '0)    $display("FAIL reset_sensor_sel: got %0d expected 0", sensor_sel); else n_pass++;
        if (sensor_en !== 1'b0)   $display("FAIL reset_sensor_en: got %b expected 0", sensor_en);    else n_pass++;
        if (raw_valid !== 1'b0)   $display("FAIL reset_raw_valid: got %b expected 0", raw_valid);    else n_pass++;
        if (raw_data !== '0)      $display("FAIL reset_raw_data: got %h expected 0", raw_data);      else n_pass++;
        if (raw_sensor !== '0)    $display("FAIL reset_raw_sensor: got %0d expected 0", raw_sensor); else n_pass++;
        if (raw_timeout !== 1'b0) $display("FAIL reset_raw_timeout: got %b expected 0", raw_timeout); else n_pass++;
        if (busy !== 1'b0)        $display("FAIL reset_busy: got %b expected 0", busy);              else n_pass++;
        if (scan_done !== 1'b0)   $display("FAIL reset_scan_done: got %b expected 0", scan_done);    else n_pass++;
        rst_n = 1'b1;
        repeat (4) tick();
        n_checks++;
        if (busy !== 1'b0) $display("FAIL release_busy: got %b expected 0", busy); else n_pass++;
    endtask

    task automatic test_single();
        int r0 = n_res, d0 = n_done_p, b0 = sel_bad;
        set_channel(50, 16'h1234, 1'b0);
        raw_ready = 1'b1;
        run_scan(16'h0004);
        wait_scan_done(400, "single_done");
        repeat (3) tick();
        n_checks += 10;
        if (n_res - r0 != 1)           $display("FAIL single_count: got %0d expected 1", n_res - r0);            else n_pass++;
        if (res_sensor[r0] !== 4'd2)   $display("FAIL single_sensor: got %0d expected 2", res_sensor[r0]);       else n_pass++;
        if (res_data[r0] !== 16'h1234) $display("FAIL single_data: got %h expected 1234", res_data[r0]);         else n_pass++;
        if (res_to[r0] !== 1'b0)       $display("FAIL single_timeout: got %b expected 0", res_to[r0]);           else n_pass++;
        if (start_sel !== 4'd2)        $display("FAIL single_sel: got %0d expected 2", start_sel);               else n_pass++;
        if (sel_bad != b0)             $display("FAIL single_sel_stable: got %0d changes expected 0", sel_bad - b0); else n_pass++;
        if (start_cyc - en_cyc != 8)   $display("FAIL single_settle: got %0d expected 8", start_cyc - en_cyc);   else n_pass++;
        if (res_lat[r0] != 50)         $display("FAIL single_latency: got %0d expected 50", res_lat[r0]);        else n_pass++;
        if (n_done_p - d0 != 1)        $display("FAIL single_done_pulses: got %0d expected 1", n_done_p - d0);   else n_pass++;
        if (busy !== 1'b0)             $display("FAIL single_idle_busy: got %b expected 0", busy);               else n_pass++;
    endtask

    task automatic test_full_sweep();
        int r0 = n_res, s0 = n_start;
        set_channel(5, 16'd100, 1'b1);
        run_scan(16'hFFFF);
        wait_scan_done(2000, "sweep_done");
        n_checks += 2;
        if (n_res - r0 != 16)   $display("FAIL sweep_count: got %0d expected 16", n_res - r0);    else n_pass++;
        if (n_start - s0 != 16) $display("FAIL sweep_starts: got %0d expected 16", n_start - s0); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (res_sensor[r0+i] !== 4'(i) || res_data[r0+i] !== 16'(100 + i) || res_to[r0+i] !== 1'b0)
                $display("FAIL sweep_result_%0d: got sensor %0d data %0d to %b expected sensor %0d data %0d to 0",
                         i, res_sensor[r0+i], res_data[r0+i], res_to[r0+i], i, 100 + i);
            else n_pass++;
        end
    endtask

    task automatic test_sparse_empty();
        int r0 = n_res, s0;
        set_channel(5, 16'd100, 1'b1);
        run_scan(16'h8001);
        wait_scan_done(400, "sparse_done");
        n_checks += 3;
        if (n_res - r0 != 2)          $display("FAIL sparse_count: got %0d expected 2", n_res - r0);          else n_pass++;
        if (res_sensor[r0] !== 4'd0)  $display("FAIL sparse_first: got %0d expected 0", res_sensor[r0]);      else n_pass++;
        if (res_sensor[r0+1] !== 4'd15) $display("FAIL sparse_second: got %0d expected 15", res_sensor[r0+1]); else n_pass++;
        r0 = n_res;
        s0 = n_start;
        run_scan(16'h0000);
        wait_scan_done(20, "empty_done");
        n_checks += 3;
        if (done_cyc - req_cyc != 2) $display("FAIL empty_latency: got %0d expected 2", done_cyc - req_cyc); else n_pass++;
        if (n_start != s0)           $display("FAIL empty_starts: got %0d expected 0", n_start - s0);        else n_pass++;
        if (n_res != r0)             $display("FAIL empty_results: got %0d expected 0", n_res - r0);         else n_pass++;
    endtask

    task automatic test_timeout();
        int r0 = n_res;
        set_channel(5, 16'd100, 1'b1);
        ch_hang = 1'b1;
        ch_hang_sel = 4'd0;
        run_scan(16'h0003);
        wait_scan_done(6000, "timeout_done");
        ch_hang = 1'b0;
        n_checks += 6;
        if (n_res - r0 != 2)          $display("FAIL timeout_count: got %0d expected 2", n_res - r0);        else n_pass++;
        if (res_to[r0] !== 1'b1)      $display("FAIL timeout_flag: got %b expected 1", res_to[r0]);          else n_pass++;
        if (res_data[r0] !== 16'h0)   $display("FAIL timeout_data: got %h expected 0", res_data[r0]);        else n_pass++;
        if (res_lat[r0] != 4096)      $display("FAIL timeout_latency: got %0d expected 4096", res_lat[r0]);  else n_pass++;
        if (res_sensor[r0+1] !== 4'd1 || res_to[r0+1] !== 1'b0)
            $display("FAIL timeout_next: got sensor %0d to %b expected sensor 1 to 0", res_sensor[r0+1], res_to[r0+1]);
        else n_pass++;
        if (res_data[r0+1] !== 16'd101) $display("FAIL timeout_next_data: got %0d expected 101", res_data[r0+1]); else n_pass++;
    endtask

    task automatic test_backpressure();
        int r0 = n_res, s0 = n_start;
        logic [CW-1:0] d_snap;
        logic [SW-1:0] s_snap;
        logic t_snap;
        bit stable = 1'b1;
        set_channel(5, 16'h0A00, 1'b1);
        raw_ready = 1'b0;
        run_scan(16'h0030);
        wait_sig(0, 200, "bp_valid");
        d_snap = raw_data;
        s_snap = raw_sensor;
        t_snap = raw_timeout;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!raw_valid || raw_data !== d_snap || raw_sensor !== s_snap || raw_timeout !== t_snap || sensor_sel !== 4'd4)
                stable = 1'b0;
        end
        n_checks += 3;
        if (!stable)              $display("FAIL bp_stable: got change during stall expected stable outputs"); else n_pass++;
        if (n_start - s0 != 1)    $display("FAIL bp_no_advance: got %0d starts expected 1", n_start - s0);      else n_pass++;
        if (d_snap !== 16'h0A04)  $display("FAIL bp_data: got %h expected 0a04", d_snap);                      else n_pass++;
        raw_ready = 1'b1;
        tick();
        n_checks++;
        if (raw_valid !== 1'b0) $display("FAIL bp_release: got %b expected 0", raw_valid); else n_pass++;
        wait_scan_done(400, "bp_done");
        n_checks += 2;
        if (n_res - r0 != 2)            $display("FAIL bp_count: got %0d expected 2", n_res - r0);          else n_pass++;
        if (res_data[r0+1] !== 16'h0A05) $display("FAIL bp_second: got %h expected 0a05", res_data[r0+1]); else n_pass++;
    endtask

    task automatic test_enable();
        int r0 = n_res;
        set_channel(5, 16'h0E00, 1'b1);
        run_scan(16'h0100);
        wait_sig(1, 50, "en_sensor_en");
        repeat (2) tick();
        enable = 1'b0;
        repeat (10) tick();
        enable = 1'b1;
        wait_scan_done(400, "en_done");
        n_checks += 2;
        if (start_cyc - en_cyc != 18)   $display("FAIL en_settle: got %0d expected 18", start_cyc - en_cyc); else n_pass++;
        if (res_data[r0] !== 16'h0E08)  $display("FAIL en_data: got %h expected 0e08", res_data[r0]);      else n_pass++;
    endtask

    task automatic test_reset_mid_wait();
        int r0, d0;
        set_channel(50, 16'h0D00, 1'b1);
        run_scan(16'h0008);
        wait_sig(2, 50, "rst_wait_start");
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        n_checks += 5;
        if (meas_start !== 1'b0) $display("FAIL rst_meas_start: got %b expected 0", meas_start);  else n_pass++;
        if (sensor_en !== 1'b0)  $display("FAIL rst_sensor_en: got %b expected 0", sensor_en);    else n_pass++;
        if (sensor_sel !== '0)   $display("FAIL rst_sensor_sel: got %0d expected 0", sensor_sel); else n_pass++;
        if (busy !== 1'b0)       $display("FAIL rst_busy: got %b expected 0", busy);              else n_pass++;
        if (raw_valid !== 1'b0)  $display("FAIL rst_raw_valid: got %b expected 0", raw_valid);    else n_pass++;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        r0 = n_res;
        d0 = n_done_p;
        set_channel(5, 16'h0B00, 1'b1);
        run_scan(16'h0002);
        wait_scan_done(400, "rst_rescan_done");
        n_checks += 2;
        if (n_res - r0 != 1 || res_sensor[r0] !== 4'd1)
            $display("FAIL rst_rescan: got %0d results sensor %0d expected 1 result sensor 1", n_res - r0, res_sensor[r0]);
        else n_pass++;
        if (res_data[r0] !== 16'h0B01) $display("FAIL rst_rescan_data: got %h expected 0b01", res_data[r0]); else n_pass++;
    endtask

    task automatic test_priority();
        int r0 = n_res;
        set_channel(4096, 16'h0C00, 1'b1);
        run_scan(16'h0040);
        wait_scan_done(6000, "prio_done");
        n_checks += 3;
        if (res_to[r0] !== 1'b0)        $display("FAIL prio_timeout: got %b expected 0", res_to[r0]);       else n_pass++;
        if (res_data[r0] !== 16'h0C06)  $display("FAIL prio_data: got %h expected 0c06", res_data[r0]);     else n_pass++;
        if (res_lat[r0] != 4096)        $display("FAIL prio_latency: got %0d expected 4096", res_lat[r0]);  else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_sweep();
        test_sparse_empty();
        test_timeout();
        test_backpressure();
        test_enable();
        test_reset_mid_wait();
        test_priority();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
